seg7_digit_monitor: RTL and testbench

- Observer block on the far end of the seven-segment seconds counter output: watches the 7-bit segment bus, decodes each pattern back to a digit and checks the count sequence and tick period.
- Used as an on-chip self-check / bench checker alongside the top-level counter; outputs are flags and captured values, with no drive back into the counter.

---
 rtl/seg7_pkg.sv | 64 ++++++
 rtl/seg7_stable_filter.sv | 47 ++++
 rtl/seg7_digit_monitor.sv | 117 +++++++++++
 tb/tb_seg7_digit_monitor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: pattern constants, decode/encode helpers.
// Segment order is bit0=a .. bit6=g, active high.
package seg7_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGIT_W = 4;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef struct packed {
        logic               valid;
        logic [DIGIT_W-1:0] digit;
    } seg7_dec_t;

    // Pattern -> digit; valid=0 for blank and for any non-table pattern.
    function automatic seg7_dec_t seg7_decode(input logic [SEG_W-1:0] pattern);
        seg7_dec_t r;
        r = '{valid: 1'b1, digit: 4'd0};
        case (pattern)
            SEG_0:   r.digit = 4'd0;
            SEG_1:   r.digit = 4'd1;
            SEG_2:   r.digit = 4'd2;
            SEG_3:   r.digit = 4'd3;
            SEG_4:   r.digit = 4'd4;
            SEG_5:   r.digit = 4'd5;
            SEG_6:   r.digit = 4'd6;
            SEG_7:   r.digit = 4'd7;
            SEG_8:   r.digit = 4'd8;
            SEG_9:   r.digit = 4'd9;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

    // Digit -> pattern; out-of-range digits render blank.
    function automatic logic [SEG_W-1:0] seg7_encode(input logic [DIGIT_W-1:0] digit);
        logic [SEG_W-1:0] p;
        case (digit)
            4'd0:    p = SEG_0;
            4'd1:    p = SEG_1;
            4'd2:    p = SEG_2;
            4'd3:    p = SEG_3;
            4'd4:    p = SEG_4;
            4'd5:    p = SEG_5;
            4'd6:    p = SEG_6;
            4'd7:    p = SEG_7;
            4'd8:    p = SEG_8;
            4'd9:    p = SEG_9;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Debounce for the sampled segment bus: a pattern is accepted once it has been
// held STABLE_CYCLES cycles and differs from the previously accepted pattern.
module seg7_stable_filter
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [SEG_W-1:0] seg_r,
    output logic             accept_pulse,
    output logic [SEG_W-1:0] accepted_pattern
);

    localparam int unsigned STAB_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_FIRE = STAB_W'(STABLE_CYCLES - 1);

    logic [SEG_W-1:0]  r_cand;
    logic [SEG_W-1:0]  r_accepted;
    logic [STAB_W-1:0] r_stab_cnt;

    // Both outputs are combinational and meaningful in the accepting cycle only;
    // the consumer registers them on the same edge the filter latches r_accepted.
    assign accept_pulse     = ena && (r_stab_cnt == STAB_FIRE) && (r_cand != r_accepted);
    assign accepted_pattern = r_cand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand     <= SEG_BLANK;
            r_accepted <= SEG_BLANK;
            r_stab_cnt <= '0;
        end else if (ena) begin
            if (seg_r != r_cand) begin
                r_cand     <= seg_r;
                r_stab_cnt <= '0;
            end else if (r_stab_cnt != STAB_MAX) begin
                r_stab_cnt <= r_stab_cnt + 1'b1;
            end
            if (accept_pulse) begin
                r_accepted <= r_cand;
            end
        end
    end

endmodule

// File: rtl/seg7_digit_monitor.sv
// Observer for the seven-segment seconds counter: decodes accepted patterns and
// flags bad patterns, out-of-order digits and off-period digit changes.
module seg7_digit_monitor
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned EXPECT_PERIOD = 1000,
    parameter int unsigned TOL           = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               clear,
    input  logic [SEG_W-1:0]   seg_in,
    output logic [DIGIT_W-1:0] digit,
    output logic               digit_valid,
    output logic               change_pulse,
    output logic [CNT_W-1:0]   last_interval,
    output logic               interval_valid,
    output logic               decode_err,
    output logic               seq_err,
    output logic               timing_err
);

    localparam logic [CNT_W-1:0] PERIOD_LO = CNT_W'(EXPECT_PERIOD - TOL);
    localparam logic [CNT_W-1:0] PERIOD_HI = CNT_W'(EXPECT_PERIOD + TOL);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [SEG_W-1:0]   r_seg;
    logic [DIGIT_W-1:0] r_digit;
    logic               r_digit_valid;
    logic               r_change_pulse;
    logic [CNT_W-1:0]   r_period_cnt;
    logic [CNT_W-1:0]   r_last_interval;
    logic               r_interval_valid;
    logic               r_decode_err;
    logic               r_seq_err;
    logic               r_timing_err;

    logic               w_accept;
    logic [SEG_W-1:0]   w_accepted_pattern;
    seg7_dec_t          w_dec;
    logic [DIGIT_W-1:0] w_next_digit;
    logic               w_valid_chg;
    logic               w_bad_pat;
    logic               w_seq_bad;
    logic               w_time_bad;

    seg7_stable_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk              (clk),
        .rst_n            (rst_n),
        .ena              (ena),
        .seg_r            (r_seg),
        .accept_pulse     (w_accept),
        .accepted_pattern (w_accepted_pattern)
    );

    // Classify the pattern being accepted this cycle.
    always_comb begin
        w_dec        = seg7_decode(w_accepted_pattern);
        w_next_digit = (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
        w_valid_chg  = w_accept && w_dec.valid;
        w_bad_pat    = w_accept && !w_dec.valid && (w_accepted_pattern != SEG_BLANK);
        w_seq_bad    = w_valid_chg && r_digit_valid && (w_dec.digit != w_next_digit);
        w_time_bad   = w_valid_chg && r_digit_valid &&
                       ((r_period_cnt < PERIOD_LO) || (r_period_cnt > PERIOD_HI) ||
                        (r_period_cnt == CNT_MAX));
    end

    // The first valid change after reset only restarts the period counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg            <= SEG_BLANK;
            r_digit          <= '0;
            r_digit_valid    <= 1'b0;
            r_change_pulse   <= 1'b0;
            r_period_cnt     <= '0;
            r_last_interval  <= '0;
            r_interval_valid <= 1'b0;
            r_decode_err     <= 1'b0;
            r_seq_err        <= 1'b0;
            r_timing_err     <= 1'b0;
        end else begin
            r_change_pulse <= w_valid_chg;
            if (ena) begin
                r_seg <= seg_in;
                if (w_valid_chg) begin
                    r_period_cnt  <= CNT_W'(1);
                    r_digit       <= w_dec.digit;
                    r_digit_valid <= 1'b1;
                    if (r_digit_valid) begin
                        r_last_interval  <= r_period_cnt;
                        r_interval_valid <= 1'b1;
                    end
                end else if (r_period_cnt != CNT_MAX) begin
                    r_period_cnt <= r_period_cnt + 1'b1;
                end
                r_decode_err <= (r_decode_err && !clear) || w_bad_pat;
                r_seq_err    <= (r_seq_err    && !clear) || w_seq_bad;
                r_timing_err <= (r_timing_err && !clear) || w_time_bad;
            end
        end
    end

    assign digit          = r_digit;
    assign digit_valid    = r_digit_valid;
    assign change_pulse   = r_change_pulse && ena;
    assign last_interval  = r_last_interval;
    assign interval_valid = r_interval_valid;
    assign decode_err     = r_decode_err;
    assign seq_err        = r_seq_err;
    assign timing_err     = r_timing_err;

endmodule

// File: tb/tb_seg7_digit_monitor.sv
// Directed bench for seg7_digit_monitor: count sequence, glitch rejection,
// bad patterns, sequence and period errors, mid-run reset and ena freeze.
module tb_seg7_digit_monitor;

    localparam int unsigned CNT_W = 24;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic             clear;
    logic [6:0]       seg_in;
    logic [3:0]       digit;
    logic             digit_valid;
    logic             change_pulse;
    logic [CNT_W-1:0] last_interval;
    logic             interval_valid;
    logic             decode_err;
    logic             seq_err;
    logic             timing_err;

    int n_checks;
    int n_errors;
    int n_pulses;

    logic [6:0] pats [10];

    seg7_digit_monitor #(
        .STABLE_CYCLES (4),
        .CNT_W         (CNT_W),
        .EXPECT_PERIOD (1000),
        .TOL           (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .clear          (clear),
        .seg_in         (seg_in),
        .digit          (digit),
        .digit_valid    (digit_valid),
        .change_pulse   (change_pulse),
        .last_interval  (last_interval),
        .interval_valid (interval_valid),
        .decode_err     (decode_err),
        .seq_err        (seq_err),
        .timing_err     (timing_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (change_pulse) n_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic d, input logic s, input logic t);
        chk({tag, ".decode_err"}, 32'(decode_err), 32'(d));
        chk({tag, ".seq_err"},    32'(seq_err),    32'(s));
        chk({tag, ".timing_err"}, 32'(timing_err), 32'(t));
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    initial begin
        int d;
        n_checks = 0;
        n_errors = 0;
        n_pulses = 0;
        pats = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        rst_n  = 1'b0;
        ena    = 1'b1;
        clear  = 1'b0;
        seg_in = 7'h00;

        tick(3);
        chk("rst.digit",          32'(digit),          0);
        chk("rst.digit_valid",    32'(digit_valid),    0);
        chk("rst.change_pulse",   32'(change_pulse),   0);
        chk("rst.last_interval",  32'(last_interval),  0);
        chk("rst.interval_valid", 32'(interval_valid), 0);
        chk_flags("rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // 0..9..0, 1000 cycles apart; a 3-cycle 7F glitch sits before digit 3.
        for (int i = 0; i <= 10; i++) begin
            d = i % 10;
            seg_in = pats[d];
            tick(5);
            chk("seq.pre_pulse", 32'(change_pulse), 0);
            if (i > 0) chk("seq.pre_digit", 32'(digit), 32'((i - 1) % 10));
            tick(1);
            chk("seq.pulse", 32'(change_pulse), 1);
            chk("seq.digit", 32'(digit), 32'(d));
            chk("seq.interval_valid", 32'(interval_valid), (i >= 1) ? 1 : 0);
            if (i >= 1) chk("seq.last_interval", 32'(last_interval), 1000);
            tick(1);
            chk("seq.pulse_end", 32'(change_pulse), 0);
            if (i == 2) begin
                tick(990);
                seg_in = 7'h7F;
                tick(3);
            end else if (i < 10) begin
                tick(993);
            end
        end
        chk("seq.pulse_count", 32'(n_pulses), 11);
        chk_flags("seq", 1'b0, 1'b0, 1'b0);

        // Unknown pattern: sticky decode error, digit unchanged, then cleared.
        seg_in = 7'h49;
        tick(10);
        chk("bad.digit", 32'(digit), 0);
        chk_flags("bad", 1'b1, 1'b0, 1'b0);
        chk("bad.pulse_count", 32'(n_pulses), 11);
        clear_pulse();
        chk("bad.cleared", 32'(decode_err), 0);

        // 0 -> 1 legal, 1 -> 3 out of order.
        seg_in = 7'h06;
        tick(6);
        chk("skip.digit1", 32'(digit), 1);
        chk("skip.seq_err_ok", 32'(seq_err), 0);
        tick(4);
        seg_in = 7'h4F;
        tick(6);
        chk("skip.digit3", 32'(digit), 3);
        chk("skip.seq_err", 32'(seq_err), 1);
        clear_pulse();
        chk_flags("skip.clr", 1'b0, 1'b0, 1'b0);

        // 3 -> 4 at 1003 cycles (late), then 4 -> 5 at 1002 (edge of tolerance).
        tick(1003 - 7);
        seg_in = 7'h66;
        tick(6);
        chk("late.digit", 32'(digit), 4);
        chk("late.last_interval", 32'(last_interval), 1003);
        chk_flags("late", 1'b0, 1'b0, 1'b1);
        clear_pulse();
        chk("late.cleared", 32'(timing_err), 0);
        tick(1002 - 7);
        seg_in = 7'h6D;
        tick(6);
        chk("edge.digit", 32'(digit), 5);
        chk("edge.last_interval", 32'(last_interval), 1002);
        chk_flags("edge", 1'b0, 1'b0, 1'b0);

        // Reset mid-count at 5, resume at 8: treated as the first digit.
        tick(200);
        rst_n = 1'b0;
        tick(1);
        chk("mrst.digit", 32'(digit), 0);
        chk("mrst.digit_valid", 32'(digit_valid), 0);
        chk("mrst.last_interval", 32'(last_interval), 0);
        rst_n = 1'b1;
        seg_in = 7'h7F;
        tick(5);
        chk("mrst.pre_pulse", 32'(change_pulse), 0);
        tick(1);
        chk("mrst.pulse", 32'(change_pulse), 1);
        chk("mrst.digit8", 32'(digit), 8);
        chk("mrst.digit_valid1", 32'(digit_valid), 1);
        chk("mrst.interval_valid", 32'(interval_valid), 0);
        chk_flags("mrst", 1'b0, 1'b0, 1'b0);

        // 8 -> 9 at 997 cycles (one below tolerance).
        tick(997 - 6);
        seg_in = 7'h6F;
        tick(6);
        chk("early.digit", 32'(digit), 9);
        chk("early.interval_valid", 32'(interval_valid), 1);
        chk("early.last_interval", 32'(last_interval), 997);
        chk_flags("early", 1'b0, 1'b0, 1'b1);
        clear_pulse();

        // Blank is accepted silently.
        seg_in = 7'h00;
        tick(10);
        chk("blank.digit", 32'(digit), 9);
        chk_flags("blank", 1'b0, 1'b0, 1'b0);
        chk("blank.pulse_count", 32'(n_pulses), 17);

        // ena low freezes sampling; 9 -> 0 wrap is legal once enabled.
        ena = 1'b0;
        seg_in = 7'h3F;
        tick(20);
        chk("ena.digit_hold", 32'(digit), 9);
        chk("ena.pulse", 32'(change_pulse), 0);
        ena = 1'b1;
        tick(5);
        chk("ena.pre_pulse", 32'(change_pulse), 0);
        tick(1);
        chk("ena.pulse_on", 32'(change_pulse), 1);
        chk("ena.digit0", 32'(digit), 0);
        chk("ena.seq_err", 32'(seq_err), 0);
        tick(2);
        chk("final.pulse_count", 32'(n_pulses), 18);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
